mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning: cycles a granted access may wait for mem_ready_i before forced termination; legal range 2..65535.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 imem_valid_i  input  1  fetch request; held high with stable addr/wdata/we until imem_ready_o.
REQ-005 imem_ready_o  output  1  fetch access complete this cycle.
REQ-006 imem_addr_i  input  32  fetch byte address.
REQ-007 imem_wdata_i  input  32  fetch write data.
REQ-008 imem_we_i  input  4  fetch byte write enables.
REQ-009 imem_rdata_o  output  32  fetch read data, valid when imem_ready_o=1.
REQ-010 dmem_valid_i / dmem_ready_o / dmem_addr_i / dmem_wdata_i / dmem_we_i / dmem_rdata_o  same directions, widths, meanings as REQ-004..009, for the LSU.
REQ-011 mem_valid_o  output  1  shared memory request.
REQ-012 mem_ready_i  input  1  shared memory completion.
REQ-013 mem_addr_o  output  32; mem_wdata_o  output  32; mem_we_o  output  4: owner's request fields.
REQ-014 mem_rdata_i  input  32  shared memory read data.
REQ-015 err_o  output  1  owner's access terminated by timeout this cycle.

Function
REQ-016 FSM states IDLE, BUSY_I, BUSY_D; owner = I in BUSY_I, D in BUSY_D, none in IDLE.
REQ-017 mem_valid_o = 1 exactly when state is BUSY_I or BUSY_D; driven from state register only.
REQ-018 mem_addr_o/mem_wdata_o/mem_we_o = owner's input fields; all zero in IDLE.
REQ-019 imem_rdata_o and dmem_rdata_o SHALL both equal mem_rdata_i at all times.
REQ-020 Completion cycle: state BUSY_x and (mem_ready_i=1 or timeout); x_ready_o=1 combinationally that cycle only; non-owner ready never asserted.
REQ-021 IDLE, one valid high: next state BUSY of that requester; grant latency 1 cycle from valid to mem_valid_o.
REQ-022 IDLE, both valid: winner per Configuration section.
REQ-023 Completion in BUSY_x: next state BUSY_other if other requester's valid=1, else IDLE; owner's own valid ignored in completion cycle (no back-to-back re-grant without an IDLE cycle or intervening other grant).
REQ-024 Requests arriving during BUSY are not lost; requester holds valid until its ready.
REQ-025 Timeout counter, width clog2(TIMEOUT_CYCLES+1): cleared on entry to any BUSY state, increments each BUSY cycle without mem_ready_i.
REQ-026 Timeout: counter == TIMEOUT_CYCLES-1 and mem_ready_i=0 in BUSY -> completion per REQ-020 with err_o=1; err_o=0 in all other cycles, including mem_ready_i and timeout coincident (ready wins).
REQ-027 last_grant register (1 bit, I or D) updated to owner on each completion.
REQ-028 Arbiter never issues mem_valid_o with no requester; mem_valid_o never drops before completion.

Reset
REQ-029 rst_n=0 at rising edge: state IDLE, counter 0, last_grant=I, regardless of operation in flight; in-flight access abandoned, no ready, no err.
REQ-030 While in reset and first cycle after: mem_valid_o, imem_ready_o, dmem_ready_o, err_o, mem_addr_o, mem_wdata_o, mem_we_o all 0.

Configuration
REQ-031 Macro MEM_ARB_ROUND_ROBIN_EN defined: simultaneous IDLE requests granted to requester opposite last_grant.
REQ-032 Macro undefined: simultaneous IDLE requests always granted to D; last_grant still maintained but unused.

Verification
REQ-033 Single fetch: imem_valid_i=1, addr 0x100, mem_ready_i 2 cycles after mem_valid_o, rdata 0xDEADBEEF -> mem_addr_o=0x100, imem_ready_o 1 cycle, imem_rdata_o=0xDEADBEEF, err_o=0.
REQ-034 Simultaneous requests from IDLE after reset, I addr 0x0, D addr 0x2000 -> D granted first (both configs); I granted in the D completion cycle's next cycle with mem_addr_o=0x0.
REQ-035 Both valid continuously, mem_ready_i always 1, MEM_ARB_ROUND_ROBIN_EN defined -> grants alternate D,I,D,I; undefined -> same alternation via REQ-023, D wins every IDLE tie.
REQ-036 Timeout with TIMEOUT_CYCLES=4, dmem write we=4'b1111, mem_ready_i held 0 -> dmem_ready_o=1 and err_o=1 in 4th BUSY_D cycle, mem_valid_o low next cycle.
REQ-037 rst_n=0 asserted in 2nd cycle of BUSY_I -> next cycle IDLE, mem_valid_o=0, no imem_ready_o; request re-granted after rst_n=1 if imem_valid_i still high.
REQ-038 mem_ready_i and timeout coincident (TIMEOUT_CYCLES=2, ready on 2nd BUSY cycle) -> ready pulse, err_o=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, LSU port and shared memory port around mem_arbiter.
// slave is the arbiter's view; master is the view of whatever drives requesters and memory.
interface mem_arbiter_if;
  logic        imem_valid_i;
  logic        imem_ready_o;
  logic [31:0] imem_addr_i;
  logic [31:0] imem_wdata_i;
  logic [3:0]  imem_we_i;
  logic [31:0] imem_rdata_o;

  logic        dmem_valid_i;
  logic        dmem_ready_o;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_wdata_i;
  logic [3:0]  dmem_we_i;
  logic [31:0] dmem_rdata_o;

  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_rdata_i;

  logic        err_o;

  modport slave (
    input  imem_valid_i, imem_addr_i, imem_wdata_i, imem_we_i,
    output imem_ready_o, imem_rdata_o,
    input  dmem_valid_i, dmem_addr_i, dmem_wdata_i, dmem_we_i,
    output dmem_ready_o, dmem_rdata_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
    input  mem_ready_i, mem_rdata_i,
    output err_o
  );

  modport master (
    output imem_valid_i, imem_addr_i, imem_wdata_i, imem_we_i,
    input  imem_ready_o, imem_rdata_o,
    output dmem_valid_i, dmem_addr_i, dmem_wdata_i, dmem_we_i,
    input  dmem_ready_o, dmem_rdata_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
    output mem_ready_i, mem_rdata_i,
    input  err_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) arbiter onto one memory port with a per-access timeout.
// Define MEM_ARB_ROUND_ROBIN_EN to break idle ties against the last owner; otherwise the LSU wins ties.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          last_grant_q;   // 0: fetch, 1: LSU
  logic          owner_i, owner_d, busy;
  logic          grant_i, grant_d;
  logic          timeout, done, tie_to_d;

  assign owner_i = (state_q == BUSY_I);
  assign owner_d = (state_q == BUSY_D);
  assign busy    = owner_i | owner_d;
  assign timeout = busy && !bus.mem_ready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign done    = busy && (bus.mem_ready_i || timeout);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign tie_to_d = !last_grant_q;
`else
  assign tie_to_d = 1'b1;
`endif

  // The bus is silenced while reset is held so an access caught mid-flight never completes.
  assign grant_i = rst_n && owner_i;
  assign grant_d = rst_n && owner_d;

  assign bus.mem_valid_o  = grant_i | grant_d;
  assign bus.mem_addr_o   = grant_i ? bus.imem_addr_i  : grant_d ? bus.dmem_addr_i  : '0;
  assign bus.mem_wdata_o  = grant_i ? bus.imem_wdata_i : grant_d ? bus.dmem_wdata_i : '0;
  assign bus.mem_we_o     = grant_i ? bus.imem_we_i    : grant_d ? bus.dmem_we_i    : '0;
  assign bus.imem_ready_o = grant_i && done;
  assign bus.dmem_ready_o = grant_d && done;
  assign bus.err_o        = rst_n && timeout;
  assign bus.imem_rdata_o = bus.mem_rdata_i;
  assign bus.dmem_rdata_o = bus.mem_rdata_i;

  // NOTE: state_d is given its hold value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.imem_valid_i && bus.dmem_valid_i) state_d = tie_to_d ? BUSY_D : BUSY_I;
        else if (bus.imem_valid_i)                state_d = BUSY_I;
        else if (bus.dmem_valid_i)                state_d = BUSY_D;
      end
      // On completion the owner's own valid is ignored: the other side or IDLE comes next.
      BUSY_I:  if (done) state_d = bus.dmem_valid_i ? BUSY_D : IDLE;
      BUSY_D:  if (done) state_d = bus.imem_valid_i ? BUSY_I : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= (!busy || done) ? '0 : cnt_q + CW'(1);
      last_grant_q <= done ? owner_d : last_grant_q;
    end
  end

endmodule
